// File: rtl/alu_trace_capture.sv
// ---------------------------------------------------------------------------
// alu_trace_capture
//
// Purpose:
//   On-chip triggerable circular trace buffer for the MicroProcessor result
//   bus. After an arm pulse, samples of aluOut are recorded into a DEPTH-entry
//   ring. A masked compare fires the trigger, POST_TRIG further qualified
//   samples are stored, then the block freezes in DONE. In DONE the oldest
//   entries can be popped one per rd_en.
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   synchronous active-high reset
//   aluOut      in   [DATA_W]  observed ALU result
//   arm         in   single-cycle pulse, starts a new capture (IDLE/DONE only)
//   mode        in   0 = sample every cycle, 1 = sample only on change
//   trig_mask   in   [DATA_W]  bits taking part in the trigger compare
//   trig_value  in   [DATA_W]  trigger compare value
//   rd_en       in   pop oldest entry, honoured only in DONE
//   rd_data     out  [DATA_W]  popped entry (registered)
//   rd_ts       out  [TS_W]    popped timestamp (ALU_TRACE_TIMESTAMP_EN only)
//   rd_valid    out  one-cycle strobe, one cycle after an honoured rd_en
//   state       out  [2]  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   count       out  [clog2(DEPTH)+1]  entries currently held
//   overflow    out  sticky, an entry was overwritten since the last arm
//   done        out  state == DONE
//
// Optional feature:
//   `define ALU_TRACE_TIMESTAMP_EN adds a TS_W cycle counter (cleared on arm),
//   stores its value with each entry and exposes it on rd_ts.
// ---------------------------------------------------------------------------
module alu_trace_capture #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [DATA_W-1:0]          aluOut,
    input  logic                       arm,
    input  logic                       mode,
    input  logic [DATA_W-1:0]          trig_mask,
    input  logic [DATA_W-1:0]          trig_value,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
`ifdef ALU_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]            rd_ts,
`endif
    output logic                       rd_valid,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT              stateQ;
    stateT              stateNext;
    logic [DATA_W-1:0]  traceMem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   postCnt;
    logic               firstSample;
    logic [DATA_W-1:0]  lastVal;

    logic               trigHit;
    logic               qualified;
    logic               doArm;
    logic               doWrite;
    logic               doRead;
    logic               postLoad;
    logic               postDec;

`ifdef ALU_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]    tsCnt;
    logic [TS_W-1:0]    tsMem [DEPTH];
`endif

    assign state = stateQ;
    assign done  = (stateQ == DONE);

    // Trigger compares only the masked bits. A sample qualifies every cycle in
    // mode 0; in mode 1 only when it differs from the last stored entry, with
    // the first sample after arm always accepted since nothing is stored yet.
    assign trigHit   = ((aluOut ^ trig_value) & trig_mask) == '0;
    assign qualified = !mode || firstSample || (aluOut != lastVal);

    // State register; reset overrides everything, including an active capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next-state and datapath control. The triggering sample is written even
    // when it would not qualify in mode 1. In CAPTURE the write that brings
    // the post counter to zero also moves to DONE on the same edge. In DONE,
    // arm beats a simultaneous rd_en, and reads of an empty buffer are dropped.
    always_comb begin
        stateNext = stateQ;
        doArm     = 1'b0;
        doWrite   = 1'b0;
        doRead    = 1'b0;
        postLoad  = 1'b0;
        postDec   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (arm) begin
                    doArm     = 1'b1;
                    stateNext = ARMED;
                end
            end
            ARMED: begin
                if (trigHit) begin
                    doWrite = 1'b1;
                    if (POST_TRIG == 0) begin
                        stateNext = DONE;
                    end else begin
                        postLoad  = 1'b1;
                        stateNext = CAPTURE;
                    end
                end else if (qualified) begin
                    doWrite = 1'b1;
                end
            end
            CAPTURE: begin
                if (qualified) begin
                    doWrite = 1'b1;
                    postDec = 1'b1;
                    if (postCnt == PTR_W'(1)) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    doArm     = 1'b1;
                    stateNext = ARMED;
                end else if (rd_en && (count != '0)) begin
                    doRead = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Trace storage has no reset so it can map onto plain RAM; entries are
    // only ever read after being written in the current capture.
    always_ff @(posedge Clock) begin
        if (doWrite) begin
            traceMem[wrPtr] <= aluOut;
`ifdef ALU_TRACE_TIMESTAMP_EN
            tsMem[wrPtr]    <= tsCnt;
`endif
        end
    end

    // Pointers, occupancy and read port. When the ring is full a write pushes
    // out the oldest entry, so the read pointer follows the write pointer and
    // count stays pinned at DEPTH while overflow latches.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            postCnt     <= '0;
            firstSample <= 1'b1;
            lastVal     <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (doArm) begin
                wrPtr       <= '0;
                rdPtr       <= '0;
                count       <= '0;
                overflow    <= 1'b0;
                firstSample <= 1'b1;
            end
            if (doWrite) begin
                wrPtr       <= wrPtr + PTR_W'(1);
                lastVal     <= aluOut;
                firstSample <= 1'b0;
                if (count == CNT_W'(DEPTH)) begin
                    rdPtr    <= rdPtr + PTR_W'(1);
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (postLoad) begin
                postCnt <= PTR_W'(POST_TRIG);
            end else if (postDec) begin
                postCnt <= postCnt - PTR_W'(1);
            end
            if (doRead) begin
                rd_data  <= traceMem[rdPtr];
                rd_valid <= 1'b1;
                rdPtr    <= rdPtr + PTR_W'(1);
                count    <= count - CNT_W'(1);
            end
        end
    end

`ifdef ALU_TRACE_TIMESTAMP_EN
    // Free-running cycle counter restarted by arm; the stored stamp is the
    // counter value at the write edge. rd_ts moves together with rd_data.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tsCnt <= '0;
            rd_ts <= '0;
        end else begin
            if (doArm) begin
                tsCnt <= '0;
            end else begin
                tsCnt <= tsCnt + TS_W'(1);
            end
            if (doRead) begin
                rd_ts <= tsMem[rdPtr];
            end
        end
    end
`endif

endmodule
